tmds_rx_decoder: RTL and testbench

- Receive-side counterpart of the DVI/HDMI transmit path: one TMDS channel decoder.
- Takes unaligned 10-bit parallel words from a 1:10 deserializer, finds the word boundary using control tokens, and decodes TMDS characters back to 8-bit pixel data, DE and the C0/C1 control bits.
- Three instances (blue/green/red) sit behind the deserializers, ahead of a video timing recovery block.

---
 rtl/tmds_rx_decoder.sv | 171 +++++++++++++++++
 tb/tb_tmds_rx_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_rx_decoder.sv
// One TMDS receive channel: finds the word boundary from control tokens and decodes characters.
// Build option TMDS_RX_ERRCNT_EN adds a saturating lock-loss counter on err_cnt.
module tmds_rx_decoder #(
  parameter int LOCK_TOKENS = 8,
  parameter int SEARCH_WIN  = 1024
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [9:0]  din_raw,
  output logic [7:0]  dout,
  output logic        de,
  output logic        c0,
  output logic        c1,
  output logic        locked,
  output logic [3:0]  align_ofs,
  output logic [15:0] err_cnt
);

  localparam int TW = (SEARCH_WIN > 1) ? $clog2(SEARCH_WIN) : 1;
  localparam int CW = $clog2(LOCK_TOKENS + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(SEARCH_WIN - 1);
  localparam logic [CW-1:0] TOK_LAST  = CW'(LOCK_TOKENS - 1);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   tok_cnt_reg, tok_cnt_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [3:0]      ofs_reg, ofs_next, ofs_step;
  logic [9:0]      raw_d_reg, aligned_reg;
  logic [19:0]     window;
  logic [7:0]      dout_reg, dout_next;
  logic            de_reg, de_next, c0_reg, c0_next, c1_reg, c1_next;
  logic            is_tok;
  logic [1:0]      tok_c;
  logic [7:0]      q, dec;

  // Earlier word in the low half, so offset k picks bits k..k+9 of the serial stream.
  assign window   = {din_raw, raw_d_reg};
  assign ofs_step = (ofs_reg == 4'd9) ? 4'd0 : ofs_reg + 4'd1;

  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    case (aligned_reg)
      10'b1101010100: tok_c = 2'b00;
      10'b0010101011: tok_c = 2'b01;
      10'b0101010100: tok_c = 2'b10;
      10'b1010101011: tok_c = 2'b11;
      default:        is_tok = 1'b0;
    endcase
  end

  assign q      = aligned_reg[9] ? ~aligned_reg[7:0] : aligned_reg[7:0];
  assign dec[0] = q[0];
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_dec
      assign dec[gi] = aligned_reg[8] ? (q[gi] ^ q[gi-1]) : ~(q[gi] ^ q[gi-1]);
    end
  endgenerate

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_reg   <= SEARCH;
      tok_cnt_reg <= '0;
      timer_reg   <= '0;
      ofs_reg     <= '0;
      raw_d_reg   <= '0;
      aligned_reg <= '0;
      dout_reg    <= '0;
      de_reg      <= 1'b0;
      c0_reg      <= 1'b0;
      c1_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tok_cnt_reg <= tok_cnt_next;
      timer_reg   <= timer_next;
      ofs_reg     <= ofs_next;
      raw_d_reg   <= din_raw;
      aligned_reg <= window[ofs_reg +: 10];
      dout_reg    <= dout_next;
      de_reg      <= de_next;
      c0_reg      <= c0_next;
      c1_reg      <= c1_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tok_cnt_next = tok_cnt_reg;
    timer_next   = timer_reg;
    ofs_next     = ofs_reg;
    case (state_reg)
      SEARCH: begin
        if (is_tok && (tok_cnt_reg == TOK_LAST)) begin
          state_next   = LOCKED;
          tok_cnt_next = '0;
          timer_next   = '0;
        end else if (timer_reg == TIMER_MAX) begin
          ofs_next     = ofs_step;
          tok_cnt_next = '0;
          timer_next   = '0;
        end else begin
          timer_next   = timer_reg + TW'(1);
          tok_cnt_next = is_tok ? tok_cnt_reg + CW'(1) : '0;
        end
      end
      LOCKED: begin
        if (is_tok) begin
          timer_next = '0;
        end else if (timer_reg == TIMER_MAX) begin
          state_next   = SEARCH;
          ofs_next     = ofs_step;
          tok_cnt_next = '0;
          timer_next   = '0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  // Gated by the next state so the outputs and locked always change on the same edge.
  always_comb begin
    dout_next = dout_reg;
    de_next   = de_reg;
    c0_next   = c0_reg;
    c1_next   = c1_reg;
    if (state_next != LOCKED) begin
      dout_next = '0;
      de_next   = 1'b0;
      c0_next   = 1'b0;
      c1_next   = 1'b0;
    end else if (is_tok) begin
      de_next = 1'b0;
      c1_next = tok_c[1];
      c0_next = tok_c[0];
    end else begin
      de_next   = 1'b1;
      dout_next = dec;
    end
  end

  assign dout      = dout_reg;
  assign de        = de_reg;
  assign c0        = c0_reg;
  assign c1        = c1_reg;
  assign locked    = (state_reg == LOCKED);
  assign align_ofs = ofs_reg;

`ifdef TMDS_RX_ERRCNT_EN
  logic        lose;
  logic [15:0] err_cnt_reg;

  assign lose = (state_reg == LOCKED) && (state_next == SEARCH);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else if (lose && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Bench for tmds_rx_decoder: TMDS transmitter model feeds the decoder, serial shifter exercises alignment.
module tb_tmds_rx_decoder;

  localparam int LOCK_TOKENS = 8;
  localparam int SEARCH_WIN  = 1024;
  localparam logic [9:0] T00 = 10'b1101010100;

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  din_raw = '0;
  logic [7:0]  dout;
  logic        de, c0, c1, locked;
  logic [3:0]  align_ofs;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0] w;
    logic       tok;
    logic [7:0] b;
    logic [1:0] c;
  } item_t;

  item_t pipe[$];
  bit    serial_q[$];
  logic [7:0] exp_dout;
  logic  exp_de, exp_c0, exp_c1;
  int    exp_err = 0;

  tmds_rx_decoder #(.LOCK_TOKENS(LOCK_TOKENS), .SEARCH_WIN(SEARCH_WIN)) dut (
    .pclk(pclk), .rst(rst), .din_raw(din_raw), .dout(dout), .de(de), .c0(c0), .c1(c1),
    .locked(locked), .align_ofs(align_ofs), .err_cnt(err_cnt)
  );

  always #5 pclk = ~pclk;

  // Transmit-side TMDS encoder (transition minimisation; bit 9 chosen freely).
  function automatic logic [9:0] tmds_encode(input logic [7:0] d, input bit inv);
    logic [8:0] qm;
    int  n1;
    bit  use_xnor;
    n1 = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  function automatic item_t mk_tok(input logic [1:0] c);
    item_t it;
    case (c)
      2'b00:   it.w = 10'b1101010100;
      2'b01:   it.w = 10'b0010101011;
      2'b10:   it.w = 10'b0101010100;
      default: it.w = 10'b1010101011;
    endcase
    it.tok = 1'b1; it.b = 8'h00; it.c = c;
    return it;
  endfunction

  function automatic item_t mk_data(input logic [9:0] w, input logic [7:0] b);
    item_t it;
    it.w = w; it.tok = 1'b0; it.b = b; it.c = 2'b00;
    return it;
  endfunction

  task automatic model_clear();
    exp_dout = '0; exp_de = 1'b0; exp_c0 = 1'b0; exp_c1 = 1'b0;
  endtask

  task automatic step_raw(input logic [9:0] w);
    din_raw = w;
    @(posedge pclk);
    #1;
  endtask

  // Words appear on the outputs two edges after being presented at offset 0.
  task automatic step_item(input item_t it);
    item_t o;
    pipe.push_back(it);
    step_raw(it.w);
    if (pipe.size() > 2) begin
      o = pipe.pop_front();
      if (o.tok) begin
        exp_de = 1'b0; {exp_c1, exp_c0} = o.c;
      end else begin
        exp_de = 1'b1; exp_dout = o.b;
      end
    end
  endtask

  task automatic send_serial(input logic [9:0] w);
    for (int b = 0; b < 10; b++) serial_q.push_back(w[b]);
  endtask

  task automatic drain_one();
    logic [9:0] r;
    for (int b = 0; b < 10; b++) r[b] = serial_q.pop_front();
    step_raw(r);
  endtask

  task automatic count_loss();
`ifdef TMDS_RX_ERRCNT_EN
    if (exp_err < 65535) exp_err++;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_raw = '0;
    repeat (2) @(posedge pclk);
    #1;
    rst = 1'b0;
    pipe.delete();
    serial_q.delete();
    model_clear();
    exp_err = 0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dout, de, c1, c0, locked, align_ofs, err_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", {dout, de, c1, c0, locked, align_ofs, err_cnt});
    end
    @(posedge pclk); #1;
    rst = 1'b0;
    pipe.delete();
    model_clear();
    exp_err = 0;
  endtask

  task automatic test_reset_mid();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dout, de, c1, c0, locked, align_ofs, err_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 0", {dout, de, c1, c0, locked, align_ofs, err_cnt});
    end
    @(posedge pclk); #1;
    rst = 1'b0;
    pipe.delete();
    model_clear();
    exp_err = 0;
  endtask

  task automatic test_lock0();
    int lock_step = 0;
    for (int i = 1; i <= LOCK_TOKENS + 4; i++) begin
      step_item(mk_tok(2'b00));
      if (locked && lock_step == 0) lock_step = i;
    end
    checks++;
    if (lock_step != LOCK_TOKENS + 2) begin
      errors++;
      $display("FAIL lock_latency: got step %0d expected %0d", lock_step, LOCK_TOKENS + 2);
    end
    checks++;
    if ({dout, de, c1, c0} !== {exp_dout, exp_de, exp_c1, exp_c0}) begin
      errors++;
      $display("FAIL lock_outputs: got %h expected %h", {dout, de, c1, c0}, {exp_dout, exp_de, exp_c1, exp_c0});
    end
  endtask

  task automatic test_data_random();
    item_t it;
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 5) == 0) it = mk_tok(2'($urandom_range(0, 3)));
      else begin
        it.b = 8'($urandom);
        it = mk_data(tmds_encode(it.b, 1'($urandom_range(0, 1))), it.b);
      end
      step_item(it);
      $display("txn %0d word=%b dout=%h de=%b c1c0=%b%b", n, it.w, dout, de, c1, c0);
      checks++;
      if ({locked, dout, de, c1, c0} !== {1'b1, exp_dout, exp_de, exp_c1, exp_c0}) begin
        errors++;
        $display("FAIL random_decode[%0d]: got %h expected %h", n, {locked, dout, de, c1, c0},
                 {1'b1, exp_dout, exp_de, exp_c1, exp_c0});
      end
    end
  endtask

  task automatic test_decode_vectors();
    step_item(mk_data(10'h100, 8'h00));
    step_item(mk_data(10'b1011111111, 8'hFE));
    step_item(mk_tok(2'b10));
    checks++;
    if ({dout, de} !== {8'h00, 1'b1}) begin
      errors++; $display("FAIL data_100: got %h expected %h", {dout, de}, {8'h00, 1'b1});
    end
    step_item(mk_tok(2'b11));
    checks++;
    if ({dout, de} !== {8'hFE, 1'b1}) begin
      errors++; $display("FAIL data_2ff: got %h expected %h", {dout, de}, {8'hFE, 1'b1});
    end
    step_item(mk_tok(2'b11));
    checks++;
    if ({dout, de, c1, c0} !== {8'hFE, 3'b010}) begin
      errors++; $display("FAIL ctrl_10: got %h expected %h", {dout, de, c1, c0}, {8'hFE, 3'b010});
    end
    step_item(mk_tok(2'b11));
    checks++;
    if ({dout, de, c1, c0} !== {8'hFE, 3'b011}) begin
      errors++; $display("FAIL ctrl_11: got %h expected %h", {dout, de, c1, c0}, {8'hFE, 3'b011});
    end
  endtask

  task automatic test_lock_loss();
    for (int i = 0; i < SEARCH_WIN + 1; i++) step_item(mk_data(10'h100, 8'h00));
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL lock_hold: got %b expected 1", locked);
    end
    step_item(mk_data(10'h100, 8'h00));
    model_clear();
    count_loss();
    checks++;
    if ({locked, align_ofs, dout, de, c1, c0} !== {1'b0, 4'd1, 11'h0}) begin
      errors++;
      $display("FAIL lock_loss: got %h expected %h", {locked, align_ofs, dout, de, c1, c0}, {1'b0, 4'd1, 11'h0});
    end
    checks++;
    if (err_cnt !== 16'(exp_err)) begin
      errors++; $display("FAIL err_cnt_loss: got %0d expected %0d", err_cnt, exp_err);
    end
  endtask

  task automatic test_alignment(input int shift, input int budget);
    int cycles = 0;
    int pos = 0;
    do_reset();
    for (int i = 0; i < shift; i++) serial_q.push_back(1'($urandom_range(0, 1)));
    while (!locked && cycles < budget) begin
      send_serial(((pos % 800) < 160) ? T00 : 10'h100);
      pos++;
      while (serial_q.size() >= 10 && !locked) begin
        drain_one();
        cycles++;
      end
    end
    $display("align shift=%0d locked=%b ofs=%0d cycles=%0d", shift, locked, align_ofs, cycles);
    checks++;
    if ({locked, align_ofs} !== {1'b1, 4'(shift)}) begin
      errors++;
      $display("FAIL align_lock: got locked=%b ofs=%0d expected locked=1 ofs=%0d", locked, align_ofs, shift);
    end
    for (int i = 0; i < 16; i++) begin
      send_serial(T00);
      while (serial_q.size() >= 10) drain_one();
      checks++;
      if ({locked, de, c1, c0} !== 4'b1000) begin
        errors++; $display("FAIL blank_ctrl[%0d]: got %b expected 1000", i, {locked, de, c1, c0});
      end
    end
  endtask

  task automatic test_wrap();
    int cycles = 0;
    test_alignment(9, 10 * SEARCH_WIN + LOCK_TOKENS);
    while (locked && cycles < 2 * SEARCH_WIN) begin
      send_serial(10'h100);
      while (serial_q.size() >= 10) begin
        drain_one();
        cycles++;
      end
    end
    count_loss();
    checks++;
    if ({locked, align_ofs} !== {1'b0, 4'd0}) begin
      errors++; $display("FAIL wrap_ofs: got locked=%b ofs=%0d expected locked=0 ofs=0", locked, align_ofs);
    end
    checks++;
    if (err_cnt !== 16'(exp_err)) begin
      errors++; $display("FAIL err_cnt_wrap: got %0d expected %0d", err_cnt, exp_err);
    end
  endtask

`ifdef TMDS_RX_ERRCNT_EN
  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < LOCK_TOKENS + 4 && !locked; i++) step_raw(T00);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL sat_lock: got %b expected 1", locked);
    end
    force dut.err_cnt_reg = 16'hFFFF;
    @(posedge pclk); #1;
    release dut.err_cnt_reg;
    exp_err = 65535;
    for (int i = 0; i < SEARCH_WIN + 2; i++) step_raw(10'h100);
    count_loss();
    checks++;
    if ({locked, err_cnt} !== {1'b0, 16'(exp_err)}) begin
      errors++; $display("FAIL err_cnt_sat: got locked=%b cnt=%h expected locked=0 cnt=%h", locked, err_cnt, 16'(exp_err));
    end
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_lock0();
    test_data_random();
    test_decode_vectors();
    test_reset_mid();
    test_lock0();
    test_lock_loss();
    test_reset_mid();
    test_alignment(3, 4 * SEARCH_WIN + LOCK_TOKENS);
    test_wrap();
`ifdef TMDS_RX_ERRCNT_EN
    test_saturation();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
